// File: rtl/mac_pat_chk_if.sv
// Byte-wide AXI4-Stream receive channel feeding the MAC pattern checker.
interface mac_pat_chk_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rlast;
    logic       rready;

    modport master (
        output rdata,
        output rvalid,
        output rlast,
        input  rready
    );

    modport slave (
        input  rdata,
        input  rvalid,
        input  rlast,
        output rready
    );
endinterface

// File: rtl/mac_pat_chk.sv
// Receive-side checker for MAC pattern generator frames: compares header and
// incrementing payload byte-by-byte, classifies each frame and keeps
// saturating good/bad counters plus a sticky error summary.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first beat of a frame
// CHECK | frame being compared, per-frame flags accumulating
// SKIP  | chk_en was low at frame start; beats consumed until rlast
module mac_pat_chk #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en_i,
    input  logic             cnt_clr_i,
    input  logic [47:0]      dst_mac_i,
    input  logic [47:0]      src_mac_i,
    input  logic [15:0]      mac_dlen_i,
    mac_pat_chk_if.slave     s_axis,
    output logic             frm_done_o,
    output logic             frm_ok_o,
    output logic [3:0]       err_vec_o,
    output logic [CNT_W-1:0] good_cnt_o,
    output logic [CNT_W-1:0] bad_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, CHECK, SKIP} state_t;

    state_t           state_q;
    logic             rready_q;
    logic [15:0]      idx_q;
    logic [3:0]       flags_q;
    logic [47:0]      dst_q;
    logic [47:0]      src_q;
    logic [15:0]      dlen_q;
    logic             frm_done_q;
    logic             frm_ok_q;
    logic [3:0]       err_q;
    logic [CNT_W-1:0] good_q;
    logic [CNT_W-1:0] bad_q;
    logic             busy_q;

    logic             beat;
    logic             in_idle;
    logic [47:0]      cur_dst;
    logic [47:0]      cur_src;
    logic [15:0]      cur_dlen;
    logic [15:0]      cur_idx;
    logic [16:0]      idx17;
    logic [16:0]      exp_last;
    logic [7:0]       hdr_byte;
    logic [7:0]       pay_byte;
    logic [3:0]       beat_flags;
    logic [3:0]       frame_flags;
    logic             classify;
    logic [15:0]      idx_inc;

    // Per-beat compare; the first beat is checked against the live config
    // because the latched copy is only written on that same edge.
    always_comb begin
        beat        = s_axis.rvalid & rready_q;
        in_idle     = (state_q == IDLE);
        cur_dst     = in_idle ? dst_mac_i  : dst_q;
        cur_src     = in_idle ? src_mac_i  : src_q;
        cur_dlen    = in_idle ? mac_dlen_i : dlen_q;
        cur_idx     = in_idle ? 16'd0      : idx_q;
        idx17       = {1'b0, cur_idx};
        exp_last    = {1'b0, cur_dlen} + 17'd13;
        pay_byte    = cur_idx[7:0] - 8'd14;
        idx_inc     = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;

        hdr_byte = 8'h00;
        case (cur_idx)
            16'd0:   hdr_byte = cur_dst[47:40];
            16'd1:   hdr_byte = cur_dst[39:32];
            16'd2:   hdr_byte = cur_dst[31:24];
            16'd3:   hdr_byte = cur_dst[23:16];
            16'd4:   hdr_byte = cur_dst[15:8];
            16'd5:   hdr_byte = cur_dst[7:0];
            16'd6:   hdr_byte = cur_src[47:40];
            16'd7:   hdr_byte = cur_src[39:32];
            16'd8:   hdr_byte = cur_src[31:24];
            16'd9:   hdr_byte = cur_src[23:16];
            16'd10:  hdr_byte = cur_src[15:8];
            16'd11:  hdr_byte = cur_src[7:0];
            16'd12:  hdr_byte = cur_dlen[15:8];
            16'd13:  hdr_byte = cur_dlen[7:0];
            default: hdr_byte = 8'h00;
        endcase

        beat_flags = 4'b0000;
        if (idx17 < 17'd14) begin
            beat_flags[0] = (s_axis.rdata != hdr_byte);
        end else if (idx17 <= exp_last) begin
            beat_flags[1] = (s_axis.rdata != pay_byte);
        end else begin
            beat_flags[3] = 1'b1;
        end
        if (s_axis.rlast && (idx17 < exp_last)) begin
            beat_flags[2] = 1'b1;
        end

        frame_flags = (in_idle ? 4'b0000 : flags_q) | beat_flags;
        classify    = beat & s_axis.rlast &
                      ((in_idle & chk_en_i) | (state_q == CHECK));
    end

    // Frame FSM, beat index, flag accumulation, classification and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rready_q   <= 1'b0;
            idx_q      <= 16'd0;
            flags_q    <= 4'b0000;
            dst_q      <= 48'd0;
            src_q      <= 48'd0;
            dlen_q     <= 16'd0;
            frm_done_q <= 1'b0;
            frm_ok_q   <= 1'b0;
            err_q      <= 4'b0000;
            good_q     <= '0;
            bad_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            rready_q   <= 1'b1;
            frm_done_q <= 1'b0;

            if (beat) begin
                case (state_q)
                    IDLE: begin
                        dst_q   <= dst_mac_i;
                        src_q   <= src_mac_i;
                        dlen_q  <= mac_dlen_i;
                        idx_q   <= 16'd1;
                        flags_q <= beat_flags;
                        if (!s_axis.rlast) begin
                            state_q <= chk_en_i ? CHECK : SKIP;
                            busy_q  <= 1'b1;
                        end
                    end
                    CHECK: begin
                        flags_q <= frame_flags;
                        idx_q   <= idx_inc;
                        if (s_axis.rlast) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    SKIP: begin
                        idx_q <= idx_inc;
                        if (s_axis.rlast) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end

            if (classify) begin
                frm_done_q <= 1'b1;
                frm_ok_q   <= ~|frame_flags;
            end

            if (cnt_clr_i) begin
                good_q <= '0;
                bad_q  <= '0;
                err_q  <= 4'b0000;
            end else if (classify) begin
                if (~|frame_flags) begin
                    if (good_q != '1) good_q <= good_q + 1'b1;
                end else begin
                    if (bad_q != '1) bad_q <= bad_q + 1'b1;
                    err_q <= err_q | frame_flags;
                end
            end
        end
    end

    assign s_axis.rready = rready_q;
    assign frm_done_o    = frm_done_q;
    assign frm_ok_o      = frm_ok_q;
    assign err_vec_o     = err_q;
    assign good_cnt_o    = good_q;
    assign bad_cnt_o     = bad_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_mac_pat_chk.sv
// Directed table-driven bench for mac_pat_chk plus multi-frame sequences.
module tb_mac_pat_chk;

    localparam logic [47:0] DST = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] SRC = 48'h112233445566;

    logic        clk = 1'b0;
    logic        rst;
    logic        chk_en;
    logic        cnt_clr;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] mac_dlen;
    logic        frm_done;
    logic        frm_ok;
    logic [3:0]  err_vec;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic        busy;

    mac_pat_chk_if bus ();

    mac_pat_chk #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .chk_en_i   (chk_en),
        .cnt_clr_i  (cnt_clr),
        .dst_mac_i  (dst_mac),
        .src_mac_i  (src_mac),
        .mac_dlen_i (mac_dlen),
        .s_axis     (bus),
        .frm_done_o (frm_done),
        .frm_ok_o   (frm_ok),
        .err_vec_o  (err_vec),
        .good_cnt_o (good_cnt),
        .bad_cnt_o  (bad_cnt),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Monitor: log every classification and count busy cycles.
    int   done_cnt  = 0;
    int   busy_cyc  = 0;
    logic ok_log[$];
    always @(negedge clk) begin
        if (frm_done === 1'b1) begin
            done_cnt++;
            ok_log.push_back(frm_ok);
        end
        if (busy === 1'b1) busy_cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [15:0] dlen);
        logic [47:0] d;
        if (i < 6) begin
            d = DST >> (8 * (5 - i));
            return d[7:0];
        end else if (i < 12) begin
            d = SRC >> (8 * (11 - i));
            return d[7:0];
        end else if (i == 12) begin
            return dlen[15:8];
        end else if (i == 13) begin
            return dlen[7:0];
        end
        return 8'(i - 14);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
    endtask

    // Sends beats first..last; rlast on the final beat if do_last.
    task automatic send_bytes(input logic [15:0] dlen, input int first, input int last,
                              input bit do_last, input int bad_idx, input bit gaps,
                              input bit clr_last, input int flip);
        logic [7:0] b;
        mac_dlen = dlen;
        for (int i = first; i <= last; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bus.rvalid = 1'b0;
                bus.rlast  = 1'($urandom_range(0, 1));
                bus.rdata  = 8'hEE;
                cyc(1);
            end
            if (i == flip) chk_en = ~chk_en;
            b = exp_byte(i, dlen);
            if (i == bad_idx) b = b ^ 8'h5A;
            bus.rdata  = b;
            bus.rvalid = 1'b1;
            bus.rlast  = do_last && (i == last);
            cnt_clr    = clr_last && (i == last);
            cyc(1);
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        cnt_clr    = 1'b0;
    endtask

    typedef struct {
        logic [15:0] dlen;
        int          n;
        int          bad_idx;
        bit          chk;
        int          flip;
        bit          gaps;
        int          exp_done;
        bit          exp_ok;
        logic [3:0]  exp_err;
        int          exp_good;
        int          exp_bad;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int base;
        int bbase;

        vecs[0]  = '{16'd16,  30,  -1, 1'b1, -1, 1'b0, 1, 1'b1, 4'h0, 1, 0};
        vecs[1]  = '{16'd16,  30,   7, 1'b1, -1, 1'b0, 1, 1'b0, 4'h1, 0, 1};
        vecs[2]  = '{16'd16,  30,  20, 1'b1, -1, 1'b0, 1, 1'b0, 4'h2, 0, 1};
        vecs[3]  = '{16'd16,  21,  -1, 1'b1, -1, 1'b0, 1, 1'b0, 4'h4, 0, 1};
        vecs[4]  = '{16'd16,  36,  -1, 1'b1, -1, 1'b0, 1, 1'b0, 4'h8, 0, 1};
        vecs[5]  = '{16'd0,   14,  -1, 1'b1, -1, 1'b0, 1, 1'b1, 4'h0, 1, 0};
        vecs[6]  = '{16'd0,    1,  -1, 1'b1, -1, 1'b0, 1, 1'b0, 4'h4, 0, 1};
        vecs[7]  = '{16'd300, 314, 274, 1'b1, -1, 1'b1, 1, 1'b0, 4'h2, 0, 1};
        vecs[8]  = '{16'd300, 314, -1, 1'b1, -1, 1'b1, 1, 1'b1, 4'h0, 1, 0};
        vecs[9]  = '{16'd16,  30,  -1, 1'b0, 10, 1'b0, 0, 1'b0, 4'h0, 0, 0};
        vecs[10] = '{16'd16,  20,   3, 1'b1, -1, 1'b0, 1, 1'b0, 4'h5, 0, 1};
        vecs[11] = '{16'd16,  30,  -1, 1'b1, 10, 1'b0, 1, 1'b1, 4'h0, 1, 0};
        vecs[12] = '{16'd16,  30,  -1, 1'b0, -1, 1'b1, 0, 1'b0, 4'h0, 0, 0};

        rst        = 1'b1;
        chk_en     = 1'b1;
        cnt_clr    = 1'b0;
        dst_mac    = DST;
        src_mac    = SRC;
        mac_dlen   = 16'd16;
        bus.rdata  = 8'h00;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_rready",   64'(bus.rready), 64'd0);
        chk("rst_frm_done", 64'(frm_done), 64'd0);
        chk("rst_frm_ok",   64'(frm_ok), 64'd0);
        chk("rst_err_vec",  64'(err_vec), 64'd0);
        chk("rst_good",     64'(good_cnt), 64'd0);
        chk("rst_bad",      64'(bad_cnt), 64'd0);
        chk("rst_busy",     64'(busy), 64'd0);
        rst = 1'b0;
        cyc(1);
        chk("rready_after_rst", 64'(bus.rready), 64'd1);

        // Table-driven single frames, counters cleared before each one.
        for (int v = 0; v < 13; v++) begin
            clear_cnt();
            chk_en = vecs[v].chk;
            base   = done_cnt;
            send_bytes(vecs[v].dlen, 0, vecs[v].n - 1, 1'b1, vecs[v].bad_idx,
                       vecs[v].gaps, 1'b0, vecs[v].flip);
            cyc(3);
            chk($sformatf("v%0d_done", v), 64'(done_cnt - base), 64'(vecs[v].exp_done));
            if (vecs[v].exp_done > 0 && done_cnt > base)
                chk($sformatf("v%0d_ok", v), 64'(ok_log[base]), 64'(vecs[v].exp_ok));
            chk($sformatf("v%0d_err", v),  64'(err_vec),  64'(vecs[v].exp_err));
            chk($sformatf("v%0d_good", v), 64'(good_cnt), 64'(vecs[v].exp_good));
            chk($sformatf("v%0d_bad", v),  64'(bad_cnt),  64'(vecs[v].exp_bad));
        end
        chk_en = 1'b1;

        // Back-to-back good frames, no gaps; busy high for beats 1..29 of each.
        clear_cnt();
        base  = done_cnt;
        bbase = busy_cyc;
        for (int f = 0; f < 3; f++) send_bytes(16'd16, 0, 29, 1'b1, -1, 1'b0, 1'b0, -1);
        cyc(3);
        chk("b2b_done", 64'(done_cnt - base), 64'd3);
        for (int f = 0; f < 3 && base + f < done_cnt; f++)
            chk($sformatf("b2b_ok%0d", f), 64'(ok_log[base + f]), 64'd1);
        chk("b2b_good", 64'(good_cnt), 64'd3);
        chk("b2b_bad",  64'(bad_cnt),  64'd0);
        chk("b2b_err",  64'(err_vec),  64'd0);
        chk("b2b_busy_cycles", 64'(busy_cyc - bbase), 64'd87);
        chk("b2b_busy_idle", 64'(busy), 64'd0);

        // Header corruption in the middle frame of three.
        clear_cnt();
        base = done_cnt;
        send_bytes(16'd16, 0, 29, 1'b1, -1, 1'b0, 1'b0, -1);
        send_bytes(16'd16, 0, 29, 1'b1,  7, 1'b0, 1'b0, -1);
        send_bytes(16'd16, 0, 29, 1'b1, -1, 1'b0, 1'b0, -1);
        cyc(3);
        chk("hdr_done", 64'(done_cnt - base), 64'd3);
        if (done_cnt - base == 3) begin
            chk("hdr_ok0", 64'(ok_log[base]),     64'd1);
            chk("hdr_ok1", 64'(ok_log[base + 1]), 64'd0);
            chk("hdr_ok2", 64'(ok_log[base + 2]), 64'd1);
        end
        chk("hdr_good", 64'(good_cnt), 64'd2);
        chk("hdr_bad",  64'(bad_cnt),  64'd1);
        chk("hdr_err",  64'(err_vec),  64'd1);

        // Single-beat frame never raises busy.
        clear_cnt();
        bbase = busy_cyc;
        send_bytes(16'd0, 0, 0, 1'b1, -1, 1'b0, 1'b0, -1);
        cyc(3);
        chk("single_busy", 64'(busy_cyc - bbase), 64'd0);
        chk("single_bad",  64'(bad_cnt), 64'd1);

        // Clear coinciding with classification wins.
        clear_cnt();
        send_bytes(16'd16, 0, 29, 1'b1, 2, 1'b0, 1'b0, -1);
        cyc(2);
        chk("clr_pre_bad", 64'(bad_cnt), 64'd1);
        chk("clr_pre_err", 64'(err_vec), 64'd1);
        send_bytes(16'd16, 0, 29, 1'b1, -1, 1'b0, 1'b1, -1);
        cyc(2);
        chk("clr_good_good", 64'(good_cnt), 64'd0);
        chk("clr_good_bad",  64'(bad_cnt),  64'd0);
        chk("clr_good_err",  64'(err_vec),  64'd0);
        send_bytes(16'd16, 0, 29, 1'b1, 20, 1'b0, 1'b1, -1);
        cyc(2);
        chk("clr_bad_bad", 64'(bad_cnt), 64'd0);
        chk("clr_bad_err", 64'(err_vec), 64'd0);

        // Reset mid-frame; the tail is seen as a new, short frame.
        send_bytes(16'd16, 0, 8, 1'b0, -1, 1'b0, 1'b0, -1);
        rst = 1'b1;
        cyc(1);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        cyc(1);
        chk("midrst_rready", 64'(bus.rready), 64'd1);
        send_bytes(16'd16, 9, 29, 1'b1, -1, 1'b0, 1'b0, -1);
        cyc(3);
        chk("midrst_bad",   64'(bad_cnt),    64'd1);
        chk("midrst_good",  64'(good_cnt),   64'd0);
        chk("midrst_short", 64'(err_vec[2]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mac_pat_chk.md
Name: mac_pat_chk

Overview:
Receive-side checker for the MAC pattern generator's frames. It consumes an 8-bit AXI4-Stream frame, either looped back from the MAC RX path or taken directly from the generator output. Each frame is compared byte-by-byte against the configured header (dst MAC, src MAC, length/type) and against the incrementing payload pattern. Per-frame results drive good/bad frame counters and error status for the bring-up register bank.

Parameters:
CNT_W, 32, width of good/bad frame counters (saturating)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
chk_en  in  1  checking enable; sampled on first beat of each frame
cnt_clr  in  1  synchronous clear of counters and err_vec
dst_mac  in  48  expected destination MAC; byte 0 on wire = [47:40]
src_mac  in  48  expected source MAC; byte 6 on wire = [47:40]
mac_dlen  in  16  expected payload length; bytes 12/13 = [15:8]/[7:0]
rdata  in  8  stream data
rvalid  in  1  stream valid
rlast  in  1  last byte of frame
rready  out  1  stream ready
frm_done  out  1  one-cycle pulse: frame classified
frm_ok  out  1  result of the frame flagged by frm_done; held until next frm_done
err_vec  out  4  sticky OR of error flags over bad frames: [0] hdr, [1] payload, [2] short, [3] long
good_cnt  out  CNT_W  frames passing all checks
bad_cnt  out  CNT_W  frames failing any check
busy  out  1  high while a frame is mid-reception

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: rready=0, frm_done=0, frm_ok=0, err_vec=0, good_cnt=0, bad_cnt=0, busy=0, FSM=IDLE.
- Ready: rready is registered and goes 1 on the first cycle after rst deasserts. It stays 1 permanently; the checker never back-pressures.
- Beat acceptance: a beat is accepted when rvalid & rready. The byte index idx (16-bit) counts accepted beats within a frame, starting at 0.
- Config latch: dst_mac, src_mac and mac_dlen are latched on the first beat of each frame. Config changes mid-frame have no effect.
- exp_last = mac_dlen + 13, computed in 17 bits. mac_dlen=0 gives a 14-byte header-only frame.
- FSM IDLE: on an accepted beat, latch config and take chk_en.
  - chk_en=1 -> CHECK (or straight to classification if rlast is set on this beat).
  - chk_en=0 -> SKIP.
- FSM CHECK: compare each accepted byte and set per-frame flags:
  - idx 0-5: compare against dst_mac; mismatch sets hdr.
  - idx 6-11: compare against src_mac; mismatch sets hdr.
  - idx 12-13: compare against mac_dlen; mismatch sets hdr.
  - idx 14..exp_last: expected byte = (idx-14)[7:0], wrapping 0xFF->0x00; mismatch sets payload.
  - rlast with idx < exp_last sets short.
  - idx > exp_last sets long. The frame continues to be consumed until rlast.
  - On rlast: classify and return to IDLE.
- FSM SKIP: consume beats silently until rlast, then return to IDLE. No frm_done and no counter change.
- idx saturates at 0xFFFF and does not wrap, so a runaway frame stays long.
- Classification latency: on the clock edge after the rlast beat is accepted:
  - frm_done=1 for exactly one cycle.
  - frm_ok = no flags set.
  - good_cnt or bad_cnt increments by 1.
  - On a bad frame, err_vec |= the frame's flags.
- Counter saturation: counters saturate at all-ones.
- busy: 1 from the accepted first beat until the cycle its rlast is accepted; 0 in IDLE. A single-beat frame never raises busy.
- rvalid gaps: idle cycles with rvalid=0 mid-frame are legal. They do not advance idx or change state.
- cnt_clr:
  - Zeroes good_cnt, bad_cnt and err_vec on the next edge.
  - If cnt_clr coincides with a classification, the clear wins and the frame is not counted.
  - FSM and in-progress frame flags are unaffected.
- chk_en deasserted mid-frame: the current frame still completes and is counted.
- rst mid-frame: everything returns to reset values. The remaining beats of the interrupted frame are seen as a new frame starting at idx 0; this is expected to be counted bad.
- rlast with rvalid=0: ignored.

Test Plan:
- Back-to-back good frames: dst=0x0A0B0C0D0E0F, src=0x112233445566, mac_dlen=16; send 3 frames of 30 bytes with payload 00..0F and no gaps -> 3 frm_done pulses each with frm_ok=1, good_cnt=3, bad_cnt=0, err_vec=0.
- Header corruption: flip byte 7 of frame 2 of 3 (mac_dlen=16) -> good_cnt=2, bad_cnt=1, err_vec=4'b0001; frm_ok=0 only on the second frm_done.
- Payload wrap: mac_dlen=300; payload wraps 0xFF->0x00 and rvalid toggles randomly -> frame passes, good_cnt=1. Then corrupt payload byte 260 -> bad_cnt=1, err_vec[1]=1.
- Length errors: mac_dlen=16; send a frame with rlast at idx 20 -> short, err_vec[2]. Send a frame with rlast at idx 35 -> long, err_vec[3]. Expect bad_cnt=2 and a single frm_done per frame.
- Enable, clear and minimum frame:
  - chk_en=0 at frame start then 1 mid-frame -> frame skipped, no frm_done.
  - mac_dlen=0, 14-byte frame -> good.
  - cnt_clr on the same edge as a classification -> counters read 0.
- Reset mid-frame: assert rst at idx 8 of a 30-byte frame, then send the remaining 21 beats -> after reset rready=1, bad_cnt=1 (short), good_cnt=0.
